// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier family: FSM states,
// Booth digit encodings and the saturation-bound helper.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } booth_state_e;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } booth_digit_e;

    // Upper (hi=1) or lower (hi=0) limit of a w-bit signed value.
    function automatic longint sat_bound(input int w, input logic hi);
        if (hi) begin
            return (64'sd1 <<< (w - 1)) - 64'sd1;
        end else begin
            return -(64'sd1 <<< (w - 1));
        end
    endfunction

endpackage

// File: rtl/booth_recode.sv
// Radix-4 Booth recoder: 3-bit multiplier window and W-bit multiplicand in,
// sign-extended 2W-bit partial product (d * M) out. Purely combinational.
module booth_recode
    import booth_pkg::*;
#(
    parameter int W = 12
) (
    input  logic [2:0]     window,
    input  logic [W-1:0]   mcand,
    output logic [2*W-1:0] pp
);

    booth_digit_e   digit_s;
    logic [2*W-1:0] mext_s;

    assign mext_s = {{W{mcand[W-1]}}, mcand};

    // Map the overlapping window onto a digit in {-2,-1,0,+1,+2}.
    always_comb begin
        digit_s = ZERO;
        case (window)
            3'b000, 3'b111: digit_s = ZERO;
            3'b001, 3'b010: digit_s = POS1;
            3'b011:         digit_s = POS2;
            3'b100:         digit_s = NEG2;
            3'b101, 3'b110: digit_s = NEG1;
            default:        digit_s = ZERO;
        endcase
    end

    // Scale the multiplicand by the selected digit.
    always_comb begin
        pp = {(2*W){1'b0}};
        case (digit_s)
            POS1:    pp = mext_s;
            POS2:    pp = mext_s << 1;
            NEG1:    pp = -mext_s;
            NEG2:    pp = -(mext_s << 1);
            default: pp = {(2*W){1'b0}};
        endcase
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative signed radix-4 Booth multiplier, one digit per cycle, valid/ready
// on both sides. Define BOOTH_ROUND_EN for round-half-up + saturation to W bits.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int W    = 12,
    parameter int FRAC = 11
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   mult_1,
    input  logic [W-1:0]   mult_2,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] result,
    output logic           busy
);

    localparam int NDIG = W / 2;
`ifdef BOOTH_ROUND_EN
    localparam int LAST = NDIG + 1;
`else
    localparam int LAST = NDIG;
`endif
    localparam int CW = $clog2(LAST + 1);

    if ((W % 2) != 0 || W < 4 || FRAC < 1 || FRAC > 2*W - 2) begin : g_param_check
        $error("booth_mult_seq: W must be even and >= 4, FRAC within [1, 2W-2]");
    end

    booth_state_e   state_r, state_nxt_s;
    logic [W-1:0]   mcand_r;
    logic [W:0]     shreg_r;
    logic [2*W-1:0] acc_r;
    logic [CW-1:0]  cnt_r;
    logic [2*W-1:0] result_r;
    logic [2*W-1:0] pp_s;
    logic [2*W-1:0] final_s;

    booth_recode #(.W(W)) u_recode (
        .window (shreg_r[2:0]),
        .mcand  (mcand_r),
        .pp     (pp_s)
    );

`ifdef BOOTH_ROUND_EN
    localparam logic [2*W-1:0]        HALF   = (2*W)'(64'd1 << (FRAC - 1));
    localparam logic signed [2*W-1:0] SAT_HI = (2*W)'(sat_bound(W, 1'b1));
    localparam logic signed [2*W-1:0] SAT_LO = (2*W)'(sat_bound(W, 1'b0));

    logic [2*W-1:0] rnd_sum_s;
    logic [2*W-1:0] rnd_s;

    // Product is at most 2^(2W-2), so adding the half-LSB cannot wrap.
    assign rnd_sum_s = acc_r + HALF;
    assign rnd_s     = $signed(rnd_sum_s) >>> FRAC;

    // Clamp the rounded value (held in acc_r) to the W-bit signed range.
    always_comb begin
        final_s = acc_r;
        if ($signed(acc_r) > SAT_HI) begin
            final_s = SAT_HI;
        end else if ($signed(acc_r) < SAT_LO) begin
            final_s = SAT_LO;
        end else begin
            final_s = acc_r;
        end
    end
`else
    assign final_s = acc_r;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; CALC runs one extra cycle to register the result.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_valid) state_nxt_s = CALC;
                else          state_nxt_s = IDLE;
            end
            CALC: begin
                if (cnt_r == CW'(LAST)) state_nxt_s = DONE;
                else                    state_nxt_s = CALC;
            end
            DONE: begin
                if (out_ready) state_nxt_s = IDLE;
                else           state_nxt_s = DONE;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // Operand capture, digit accumulation and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r  <= {W{1'b0}};
            shreg_r  <= {(W+1){1'b0}};
            acc_r    <= {(2*W){1'b0}};
            cnt_r    <= {CW{1'b0}};
            result_r <= {(2*W){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        mcand_r <= mult_2;
                        shreg_r <= {mult_1, 1'b0};
                        acc_r   <= {(2*W){1'b0}};
                        cnt_r   <= {CW{1'b0}};
                    end
                end
                CALC: begin
                    if (cnt_r < CW'(NDIG)) begin
                        acc_r   <= acc_r + (pp_s << {cnt_r, 1'b0});
                        shreg_r <= {{2{shreg_r[W]}}, shreg_r[W:2]};
                        cnt_r   <= cnt_r + CW'(1);
`ifdef BOOTH_ROUND_EN
                    end else if (cnt_r == CW'(NDIG)) begin
                        acc_r   <= rnd_s;
                        cnt_r   <= cnt_r + CW'(1);
`endif
                    end else begin
                        result_r <= final_s;
                    end
                end
                default: begin
                    result_r <= result_r;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);
    assign busy      = (state_r != IDLE);
    assign result    = result_r;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Self-checking bench for booth_mult_seq: directed corner cases, back-pressure,
// mid-operation reset and random operands against an arithmetic reference.
module tb_booth_mult_seq;

    localparam int W    = 12;
    localparam int FRAC = 11;
`ifdef BOOTH_ROUND_EN
    localparam int LAT = W/2 + 2;
`else
    localparam int LAT = W/2 + 1;
`endif

    logic           clk;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   mult_1;
    logic [W-1:0]   mult_2;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] result;
    logic           busy;

    int total;
    int bad;

    booth_mult_seq #(.W(W), .FRAC(FRAC)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mult_1    (mult_1),
        .mult_2    (mult_2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input int a, input int b);
        longint     p;
        logic [63:0] pv;
        p = longint'(a) * longint'(b);
`ifdef BOOTH_ROUND_EN
        p = (p + (64'sd1 <<< (FRAC - 1))) >>> FRAC;
        if (p > (64'sd1 <<< (W - 1)) - 64'sd1) p = (64'sd1 <<< (W - 1)) - 64'sd1;
        if (p < -(64'sd1 <<< (W - 1)))         p = -(64'sd1 <<< (W - 1));
`endif
        pv = p;
        return pv[2*W-1:0];
    endfunction

    task automatic do_op(input int a, input int b, input int stall, input bit disturb, input string tag);
        logic [2*W-1:0] exp;
        int lat;
        exp = model(a, b);
        @(negedge clk);
        chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
        in_valid  = 1'b1;
        mult_1    = W'(a);
        mult_2    = W'(b);
        out_ready = (stall == 0);
        @(posedge clk); #1;
        if (disturb) begin
            mult_1 = W'(a + 7);
            mult_2 = W'(b - 3);
        end else begin
            in_valid = 1'b0;
        end
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, "_lat"}, 64'(lat), 64'(LAT));
        chk({tag, "_res"}, 64'(result), 64'(exp));
        if (stall > 0) begin
            for (int i = 0; i < stall; i++) begin
                @(posedge clk); #1;
                chk({tag, "_hold_v"}, 64'(out_valid), 64'd1);
                chk({tag, "_hold_r"}, 64'(result), 64'(exp));
                chk({tag, "_hold_ir"}, 64'(in_ready), 64'd0);
            end
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk({tag, "_drop_v"}, 64'(out_valid), 64'd0);
        chk({tag, "_idle"}, 64'(in_ready), 64'd1);
        chk({tag, "_keep"}, 64'(result), 64'(exp));
    endtask

    initial begin
        int  a;
        int  b;
        bit  seen;
        total     = 0;
        bad       = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mult_1    = {W{1'b0}};
        mult_2    = {W{1'b0}};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", 64'(result), 64'd0);
        rst = 1'b0;

        // Directed corner products
        do_op(3, -5, 0, 1'b0, "d_3x-5");
`ifndef BOOTH_ROUND_EN
        chk("d_3x-5_const", 64'(result), 64'h0000_0000_00FF_FFF1);
`endif
        do_op(-2048, -2048, 0, 1'b0, "d_minmin");
        do_op(2047, 2047, 0, 1'b0, "d_maxmax");
        do_op(1024, 1024, 0, 1'b0, "d_1024sq");
        do_op(3, 341, 0, 1'b0, "d_3x341");
        do_op(3, 342, 0, 1'b0, "d_3x342");
        do_op(-2048, 2047, 0, 1'b0, "d_minmax");
        do_op(0, -1, 0, 1'b0, "d_zero");

        // Back-pressure and ignored in_valid during CALC
        do_op(5, -7, 5, 1'b0, "bp");
        do_op(-123, 456, 0, 1'b1, "ign");

        // Reset pulse at CALC cycle 3
        @(negedge clk);
        in_valid  = 1'b1;
        mult_1    = W'(3);
        mult_2    = W'(-5);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mid_busy", 64'(busy), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid_in_ready", 64'(in_ready), 64'd1);
        chk("mid_out_valid", 64'(out_valid), 64'd0);
        chk("mid_result", 64'(result), 64'd0);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("mid_no_spurious", 64'(seen), 64'd0);

        // Random operand pairs
        for (int n = 0; n < 2000; n++) begin
            a = int'($urandom_range(4095, 0)) - 2048;
            b = int'($urandom_range(4095, 0)) - 2048;
            do_op(a, b, 0, 1'b0, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
